// File: rtl/bt_radio_pkg.sv
// Shared types and constants for the BT radio sequencer.
//   state_e : sequencer FSM states (IDLE -> LOAD -> SETTLE -> ACTIVE -> IDLE)
//   dir_e   : burst direction latched with the request
//   CHAN_W  : channel index width (freq = 2402 + k MHz)
//   MAX_CHAN: highest legal channel index
package bt_radio_pkg;

    localparam int unsigned CHAN_W   = 7;
    localparam int unsigned MAX_CHAN = 78;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        ACTIVE = 2'd3
    } state_e;

    typedef enum logic {
        DIR_TX = 1'b0,
        DIR_RX = 1'b1
    } dir_e;

endpackage

// File: rtl/bt_radio_settle_cnt.sv
// Loadable saturating down-counter with a terminal flag.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous reset, active high (counter clears to 0)
//   load_i     - load load_val_i this cycle (has priority over en_i)
//   load_val_i - value to load
//   en_i       - count down by one; holds at 0, never wraps
//   done_o     - counter is at 0
module bt_radio_settle_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/bt_radio_seq.sv
// BT radio sequencer: accepts TX/RX burst requests on a channel, pulses the frequency
// load, waits out the PLL settle time, then enables the radio TX or RX path and moves
// bits between baseband and radio. One burst in flight at a time.
// Optional feature: define BT_RX_TIMEOUT_EN to close an RX window automatically after
// RX_TIMEOUT_CYC enabled cycles (rx_timeout_p pulses); otherwise RX stays open until
// stop_req and rx_timeout_p is held at 0.
// Ports:
//   clk_6M, rst                 - 6 MHz clock, asynchronous active-high reset
//   tx_req, rx_req, stop_req    - 1-cycle request pulses; chan sampled with tx/rx_req
//   bb_txbit, radio_rxbit       - data bits from baseband / radio
//   k, rxk                      - channel to radio; rxk = k only while rxen
//   loadfreq_p                  - 1-cycle frequency load pulse
//   txen, rxen, ready, busy     - radio enables, burst active, not idle
//   txbitin, bb_rxbit           - registered data bits to radio / baseband
//   err_p, rx_timeout_p         - illegal channel reject, RX window expiry
// All outputs are registered.
module bt_radio_seq #(
    parameter int unsigned PLL_SETTLE_CYC = 600,
    parameter int unsigned RX_TIMEOUT_CYC = 1500,
    parameter int unsigned MAX_CHAN       = bt_radio_pkg::MAX_CHAN
) (
    input  logic                            clk_6M,
    input  logic                            rst,
    input  logic                            tx_req,
    input  logic                            rx_req,
    input  logic                            stop_req,
    input  logic [bt_radio_pkg::CHAN_W-1:0] chan,
    input  logic                            bb_txbit,
    input  logic                            radio_rxbit,
    output logic [bt_radio_pkg::CHAN_W-1:0] k,
    output logic [bt_radio_pkg::CHAN_W-1:0] rxk,
    output logic                            loadfreq_p,
    output logic                            txen,
    output logic                            rxen,
    output logic                            txbitin,
    output logic                            bb_rxbit,
    output logic                            busy,
    output logic                            ready,
    output logic                            err_p,
    output logic                            rx_timeout_p
);

    import bt_radio_pkg::*;

    localparam int unsigned SETTLE_W = $clog2(PLL_SETTLE_CYC + 1);

    if (PLL_SETTLE_CYC < 1 || RX_TIMEOUT_CYC < 1 || MAX_CHAN >= (1 << CHAN_W))
    begin : g_param_check
        $error("bt_radio_seq: illegal parameter combination");
    end

    state_e              state_q, state_d;
    dir_e                dir_q, dir_d;
    logic [CHAN_W-1:0]   k_q, k_d;
    logic [CHAN_W-1:0]   rxk_q, rxk_d;
    logic                loadfreq_p_q, loadfreq_p_d;
    logic                txen_q, txen_d;
    logic                rxen_q, rxen_d;
    logic                txbitin_q, txbitin_d;
    logic                bb_rxbit_q, bb_rxbit_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                err_p_q, err_p_d;
    logic                rx_timeout_p_q, rx_timeout_p_d;
    logic                settle_done;
    logic                win_done;

    // Loaded during LOAD with PLL_SETTLE_CYC-1 so that done is seen on the last of
    // PLL_SETTLE_CYC SETTLE cycles and the enables rise on the following edge.
    bt_radio_settle_cnt #(
        .WIDTH (SETTLE_W)
    ) u_settle_cnt (
        .clk_i      (clk_6M),
        .rst_i      (rst),
        .load_i     (state_q == LOAD),
        .load_val_i (SETTLE_W'(PLL_SETTLE_CYC - 1)),
        .en_i       (state_q == SETTLE),
        .done_o     (settle_done)
    );

`ifdef BT_RX_TIMEOUT_EN
    localparam int unsigned WIN_W = $clog2(RX_TIMEOUT_CYC + 1);

    // Held loaded through SETTLE, counts while the RX window is open.
    bt_radio_settle_cnt #(
        .WIDTH (WIN_W)
    ) u_win_cnt (
        .clk_i      (clk_6M),
        .rst_i      (rst),
        .load_i     (state_q == SETTLE),
        .load_val_i (WIN_W'(RX_TIMEOUT_CYC - 1)),
        .en_i       ((state_q == ACTIVE) && (dir_q == DIR_RX)),
        .done_o     (win_done)
    );
`else
    assign win_done = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        k_d            = k_q;
        loadfreq_p_d   = 1'b0;
        err_p_d        = 1'b0;
        rx_timeout_p_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_req || rx_req) begin
                    if (chan > CHAN_W'(MAX_CHAN)) begin
                        err_p_d = 1'b1;
                    end else begin
                        state_d      = LOAD;
                        k_d          = chan;
                        // TX wins when both requests arrive together
                        dir_d        = tx_req ? DIR_TX : DIR_RX;
                        loadfreq_p_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (stop_req) begin
                    state_d = IDLE;
                end else if (settle_done) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // stop_req has priority over a same-cycle window expiry
                if (stop_req) begin
                    state_d = IDLE;
                end else if ((dir_q == DIR_RX) && win_done) begin
                    state_d        = IDLE;
                    rx_timeout_p_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs follow the next state so they line up with it.
        txen_d     = (state_d == ACTIVE) && (dir_d == DIR_TX);
        rxen_d     = (state_d == ACTIVE) && (dir_d == DIR_RX);
        ready_d    = txen_d | rxen_d;
        busy_d     = (state_d != IDLE);
        rxk_d      = rxen_d ? k_d : '0;
        txbitin_d  = txen_d & bb_txbit;
        bb_rxbit_d = rxen_d & radio_rxbit;
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            dir_q          <= DIR_TX;
            k_q            <= '0;
            rxk_q          <= '0;
            loadfreq_p_q   <= 1'b0;
            txen_q         <= 1'b0;
            rxen_q         <= 1'b0;
            txbitin_q      <= 1'b0;
            bb_rxbit_q     <= 1'b0;
            busy_q         <= 1'b0;
            ready_q        <= 1'b0;
            err_p_q        <= 1'b0;
            rx_timeout_p_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            k_q            <= k_d;
            rxk_q          <= rxk_d;
            loadfreq_p_q   <= loadfreq_p_d;
            txen_q         <= txen_d;
            rxen_q         <= rxen_d;
            txbitin_q      <= txbitin_d;
            bb_rxbit_q     <= bb_rxbit_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            err_p_q        <= err_p_d;
            rx_timeout_p_q <= rx_timeout_p_d;
        end
    end

    assign k            = k_q;
    assign rxk          = rxk_q;
    assign loadfreq_p   = loadfreq_p_q;
    assign txen         = txen_q;
    assign rxen         = rxen_q;
    assign txbitin      = txbitin_q;
    assign bb_rxbit     = bb_rxbit_q;
    assign busy         = busy_q;
    assign ready        = ready_q;
    assign err_p        = err_p_q;
    assign rx_timeout_p = rx_timeout_p_q;

endmodule
